// File: rtl/multi_last_cnt_pkg.sv
// Shared types and helpers for the multi-queue last-address counter.
package quickq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } mlc_state_t;

  // Last occupied slot; an empty queue reports slot 0.
  function automatic int unsigned mlc_last_addr(input int unsigned count);
    return (count == 32'd0) ? 32'd0 : count - 32'd1;
  endfunction

endpackage

// File: rtl/multi_last_cnt_if.sv
// Commit handshake and update report bundle between queue control and the counter.
interface multi_last_cnt_if
  import quickq_pkg::*;
#(
  parameter int NUM_Q = 4,
  parameter int DEPTH = 16
);
  localparam int QW     = $clog2(NUM_Q);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              op_valid;
  logic              op_ready;
  logic [QW-1:0]     op_q;
  logic              op_enq;
  logic              op_deq;
  logic              upd_valid;
  logic [QW-1:0]     upd_q;
  logic [ADDR_W-1:0] upd_last;
  logic [CNT_W-1:0]  upd_count;
  logic              err_ovf;
  logic              err_udf;

  modport master (
    output op_valid, op_q, op_enq, op_deq,
    input  op_ready, upd_valid, upd_q, upd_last, upd_count, err_ovf, err_udf
  );

  modport slave (
    input  op_valid, op_q, op_enq, op_deq,
    output op_ready, upd_valid, upd_q, upd_last, upd_count, err_ovf, err_udf
  );

endinterface

// File: rtl/multi_last_cnt_lane_next.sv
// Next-count and error decode for one op on the selected queue.
module mlc_lane_next
  import quickq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic [CNT_W-1:0] c,
  input  logic             enq,
  input  logic             deq,
  output logic [CNT_W-1:0] next_c,
  output logic             ovf,
  output logic             udf
);

  always_comb begin
    next_c = c;
    ovf    = 1'b0;
    udf    = 1'b0;
    // enq together with deq is a replace and leaves the count alone.
    if (enq && !deq) begin
      if (c == CNT_W'(DEPTH)) ovf    = 1'b1;
      else                    next_c = c + CNT_W'(1);
    end else if (deq && !enq) begin
      if (c == '0) udf    = 1'b1;
      else         next_c = c - CNT_W'(1);
    end
  end

endmodule

// File: rtl/multi_last_cnt.sv
// Per-queue occupancy and last-address tracking with a one-queue-per-cycle clear sweep.
module multi_last_cnt
  import quickq_pkg::*;
#(
  parameter  int NUM_Q  = 4,
  parameter  int DEPTH  = 16,
  localparam int QW     = $clog2(NUM_Q),
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  multi_last_cnt_if.slave      bus,
  input  logic [QW-1:0]        rd_q,
  output logic [CNT_W-1:0]     rd_count,
  output logic                 rd_full,
  output logic                 rd_empty,
  output logic                 busy
);

  mlc_state_t        r_state;
  logic [QW-1:0]     r_clr_idx;
  logic              r_busy;
  logic              r_upd_valid;
  logic [QW-1:0]     r_upd_q;
  logic [ADDR_W-1:0] r_upd_last;
  logic [CNT_W-1:0]  r_upd_count;
  logic              r_err_ovf;
  logic              r_err_udf;
  logic [CNT_W-1:0]  r_count [NUM_Q];

  logic              w_accept;
  logic [CNT_W-1:0]  w_cur_c;
  logic [CNT_W-1:0]  w_next_c;
  logic              w_ovf;
  logic              w_udf;

  // clr wins over a same-cycle op.
  assign bus.op_ready = (r_state == IDLE) && !clr;
  assign w_accept     = bus.op_valid && bus.op_ready;
  assign w_cur_c      = r_count[bus.op_q];

  mlc_lane_next #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_lane_next (
    .c      (w_cur_c),
    .enq    (bus.op_enq),
    .deq    (bus.op_deq),
    .next_c (w_next_c),
    .ovf    (w_ovf),
    .udf    (w_udf)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_Q; gi++) begin : g_count
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_count[gi] <= '0;
        end else if (r_state == CLEAR && r_clr_idx == QW'(gi)) begin
          r_count[gi] <= '0;
        end else if (w_accept && bus.op_q == QW'(gi)) begin
          r_count[gi] <= w_next_c;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_clr_idx   <= '0;
      r_busy      <= 1'b0;
      r_upd_valid <= 1'b0;
      r_upd_q     <= '0;
      r_upd_last  <= '0;
      r_upd_count <= '0;
      r_err_ovf   <= 1'b0;
      r_err_udf   <= 1'b0;
    end else begin
      r_upd_valid <= w_accept;
      r_err_ovf   <= w_accept && w_ovf;
      r_err_udf   <= w_accept && w_udf;
      if (w_accept) begin
        r_upd_q     <= bus.op_q;
        r_upd_count <= w_next_c;
        r_upd_last  <= ADDR_W'(mlc_last_addr(32'(w_next_c)));
      end
      case (r_state)
        IDLE: begin
          if (clr) begin
            r_state   <= CLEAR;
            r_clr_idx <= '0;
            r_busy    <= 1'b1;
          end
        end
        CLEAR: begin
          if (r_clr_idx == QW'(NUM_Q - 1)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_clr_idx <= r_clr_idx + QW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.upd_valid = r_upd_valid;
  assign bus.upd_q     = r_upd_q;
  assign bus.upd_last  = r_upd_last;
  assign bus.upd_count = r_upd_count;
  assign bus.err_ovf   = r_err_ovf;
  assign bus.err_udf   = r_err_udf;

  assign rd_count = r_count[rd_q];
  assign rd_full  = (rd_count == CNT_W'(DEPTH));
  assign rd_empty = (rd_count == '0);
  assign busy     = r_busy;

endmodule

// File: tb/tb_multi_last_cnt.sv
// Directed scoreboard bench for multi_last_cnt: driver queues expected updates, monitor checks them.
module tb_multi_last_cnt;

  localparam int NUM_Q  = 4;
  localparam int DEPTH  = 16;
  localparam int QW     = $clog2(NUM_Q);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef struct {
    int q;
    int cnt;
    int last;
    int ovf;
    int udf;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic [QW-1:0]    rd_q;
  logic [CNT_W-1:0] rd_count;
  logic             rd_full;
  logic             rd_empty;
  logic             busy;

  int   total;
  int   bad;
  exp_t sb[$];

  multi_last_cnt_if #(.NUM_Q(NUM_Q), .DEPTH(DEPTH)) bus ();

  multi_last_cnt #(.NUM_Q(NUM_Q), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .bus      (bus.slave),
    .rd_q     (rd_q),
    .rd_count (rd_count),
    .rd_full  (rd_full),
    .rd_empty (rd_empty),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check_rd(input int q, input int exp_cnt);
    rd_q = QW'(q);
    #1;
    check($sformatf("rd_count[q%0d]", q), int'(rd_count), exp_cnt);
  endtask

  // Present one op for one cycle and queue the response it should produce.
  task automatic do_op(input int q, input int enq, input int deq,
                       input int cnt, input int last, input int ovf, input int udf);
    exp_t e;
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_q     = QW'(q);
    bus.op_enq   = enq[0];
    bus.op_deq   = deq[0];
    #1;
    check("op_ready", int'(bus.op_ready), 1);
    e.q = q; e.cnt = cnt; e.last = last; e.ovf = ovf; e.udf = udf;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.op_enq   = 1'b0;
    bus.op_deq   = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (bus.upd_valid) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL upd_unexpected: got q=%0d count=%0d want no update",
                   bus.upd_q, bus.upd_count);
        end else begin
          e = sb.pop_front();
          if (int'(bus.upd_q) != e.q || int'(bus.upd_count) != e.cnt ||
              int'(bus.upd_last) != e.last || int'(bus.err_ovf) != e.ovf ||
              int'(bus.err_udf) != e.udf) begin
            bad++;
            $display("FAIL upd: got q=%0d cnt=%0d last=%0d ovf=%0d udf=%0d want q=%0d cnt=%0d last=%0d ovf=%0d udf=%0d",
                     bus.upd_q, bus.upd_count, bus.upd_last, bus.err_ovf, bus.err_udf,
                     e.q, e.cnt, e.last, e.ovf, e.udf);
          end else begin
            $display("upd q=%0d cnt=%0d last=%0d ovf=%0d udf=%0d ok",
                     e.q, e.cnt, e.last, e.ovf, e.udf);
          end
        end
      end else if (bus.err_ovf || bus.err_udf) begin
        total++;
        bad++;
        $display("FAIL err_without_upd: got ovf=%0d udf=%0d want 0 0", bus.err_ovf, bus.err_udf);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int ld[4];
    int busy_cycles;
    total = 0;
    bad   = 0;
    ld    = '{3, 7, 1, 16};
    rst_n = 1'b0;
    clr   = 1'b0;
    rd_q  = '0;
    bus.op_valid = 1'b0;
    bus.op_q     = '0;
    bus.op_enq   = 1'b0;
    bus.op_deq   = 1'b0;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int q = 0; q < NUM_Q; q++) begin
      check_rd(q, 0);
      check($sformatf("rd_empty[q%0d]", q), int'(rd_empty), 1);
    end
    check("upd_valid_rst", int'(bus.upd_valid), 0);
    check("op_ready_rst", int'(bus.op_ready), 1);
    check("busy_rst", int'(busy), 0);

    // Fill q2, then overflow
    for (int i = 0; i < 16; i++) do_op(2, 1, 0, i + 1, i, 0, 0);
    idle();
    rd_q = 2'd2;
    #1;
    check("rd_full_q2", int'(rd_full), 1);
    do_op(2, 1, 0, 16, 15, 1, 0);
    idle();
    check_rd(2, 16);

    // Drain q2, then underflow
    for (int i = 15; i >= 0; i--) do_op(2, 0, 1, i, (i == 0) ? 0 : i - 1, 0, 0);
    idle();
    rd_q = 2'd2;
    #1;
    check("rd_empty_q2", int'(rd_empty), 1);
    do_op(2, 0, 1, 0, 0, 0, 1);
    idle();
    check_rd(2, 0);

    // Replace on q1 at 5 and on empty q3, plus a refresh
    for (int i = 0; i < 5; i++) do_op(1, 1, 0, i + 1, i, 0, 0);
    do_op(1, 1, 1, 5, 4, 0, 0);
    do_op(3, 1, 1, 0, 0, 0, 0);
    do_op(3, 0, 0, 0, 0, 0, 0);
    idle();
    check_rd(1, 5);

    // Load 3,7,1,16 then clear with a competing op
    for (int i = 0; i < 3; i++) do_op(0, 1, 0, i + 1, i, 0, 0);
    for (int i = 5; i < 7; i++) do_op(1, 1, 0, i + 1, i, 0, 0);
    do_op(2, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) do_op(3, 1, 0, i + 1, i, 0, 0);
    idle();
    for (int q = 0; q < NUM_Q; q++) check_rd(q, ld[q]);
    @(negedge clk);
    clr          = 1'b1;
    bus.op_valid = 1'b1;
    bus.op_q     = '0;
    bus.op_enq   = 1'b1;
    #1;
    check("op_ready_clr", int'(bus.op_ready), 0);
    @(negedge clk);
    clr          = 1'b0;
    bus.op_valid = 1'b0;
    bus.op_enq   = 1'b0;
    busy_cycles  = 0;
    for (int n = 0; n < 10; n++) begin
      if (busy) busy_cycles++;
      @(negedge clk);
    end
    check("busy_cycles", busy_cycles, 4);
    for (int q = 0; q < NUM_Q; q++) check_rd(q, 0);
    check("op_ready_after_clr", int'(bus.op_ready), 1);

    // Async reset while an op result is being reported
    do_op(0, 1, 0, 1, 0, 0, 0);
    idle();
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_q     = '0;
    bus.op_enq   = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("upd_valid_midop", int'(bus.upd_valid), 0);
    check("upd_count_midop", int'(bus.upd_count), 0);
    check_rd(0, 0);
    bus.op_valid = 1'b0;
    bus.op_enq   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Async reset mid-sweep
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    check("busy_sweep", int'(busy), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("busy_midsweep_rst", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("op_ready_post_rst", int'(bus.op_ready), 1);
    repeat (3) @(negedge clk);
    #1;
    check("busy_post_rst", int'(busy), 0);
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_last_cnt.md
Name: multi_last_cnt

Overview:
- Parametrised, multi-queue successor to the single-pointer last counter in QuickQ.
- Tracks occupancy count and last-entry address for NUM_Q independent queues of DEPTH entries each.
- Applies enq/deq commits through a valid/ready handshake and reports the updated last address one cycle later.
- Adds full/empty flags, overflow/underflow error pulses and a multi-cycle clear sweep. Sits between the QuickQ queue control FSM and the entry storage.

Parameters:
- NUM_Q, 4, number of independent queues (>=2).
- DEPTH, 16, entries per queue (>=2).
- QW, $clog2(NUM_Q), queue-select width (localparam, derived).
- ADDR_W, $clog2(DEPTH), last-address width (localparam, derived).
- CNT_W, $clog2(DEPTH+1), occupancy count width (localparam, derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  request a clear sweep of all queues (level, sampled in IDLE).
- op_valid  in  1  commit request.
- op_ready  out  1  commit accepted when op_valid && op_ready.
- op_q  in  QW  target queue.
- op_enq  in  1  enqueue one entry.
- op_deq  in  1  dequeue one entry.
- upd_valid  out  1  one-cycle pulse, result of an accepted op.
- upd_q  out  QW  queue of the reported result.
- upd_last  out  ADDR_W  new last address of upd_q.
- upd_count  out  CNT_W  new count of upd_q.
- err_ovf  out  1  one-cycle pulse: enq-only on a full queue.
- err_udf  out  1  one-cycle pulse: deq-only on an empty queue.
- rd_q  in  QW  status read select.
- rd_count  out  CNT_W  count of rd_q (combinational).
- rd_full  out  1  rd_count == DEPTH.
- rd_empty  out  1  rd_count == 0.
- busy  out  1  clear sweep in progress.

Behaviour:
- Reset (rst_n low, asynchronous)
  - All counts = 0.
  - FSM = IDLE.
  - upd_valid, upd_q, upd_last, upd_count, err_ovf, err_udf and busy = 0.
  - No sweep is required after reset.
- FSM states
  - IDLE -> CLEAR when clr = 1.
  - CLEAR writes count = 0 for one queue per cycle, index 0..NUM_Q-1 (store is modelled as single-write-port).
  - CLEAR -> IDLE after writing index NUM_Q-1, so the sweep takes exactly NUM_Q cycles.
  - busy = 1 throughout CLEAR. clr is ignored during CLEAR.
- op_ready = (state == IDLE) && !clr, so clr has priority over a same-cycle op.
- Accepted op on queue q with count c; all results registered, latency 1:
  - enq only, c < DEPTH: c+1.
  - enq only, c == DEPTH: count unchanged; err_ovf pulses.
  - deq only, c > 0: c-1.
  - deq only, c == 0: count unchanged; err_udf pulses.
  - enq && deq: count unchanged (replace, legal even when full or empty); no error.
  - neither: count unchanged (refresh).
- upd_valid pulses for every accepted op, including error and refresh cases, carrying q and the post-op values.
- Last address = (count == 0) ? 0 : count-1, truncated to ADDR_W.
  - Range 0..DEPTH-1. No wrap is possible because count saturates at both ends.
- Count registers update on the accept edge. Back-to-back ops to the same queue therefore see the updated count, with no bubble and no forwarding logic.
- rd_* reflect committed state, so a read of the queue being updated shows the new value the cycle after accept.
- Reset asserted mid-sweep or mid-op: immediately back to reset values. The in-flight op is dropped and upd_valid does not pulse.

Decomposition:
- quickq_pkg holds:
  - typedef enum {IDLE, CLEAR} mlc_state_t.
  - A function computing last address from count.
- One sub-module, mlc_lane_next: combinational per-op next-count and error computation (inputs c, enq, deq; outputs next_c, ovf, udf), instantiated once on the selected queue.

Test Plan:
- Reset: hold rst_n low 3 cycles, release -> all rd_count = 0, rd_empty = 1, upd_valid = 0, op_ready = 1.
- Fill q2: 16 enq ops back-to-back -> upd_last 0,1,...,15; then rd_full = 1. A 17th enq -> err_ovf pulse, upd_count = 16, upd_last = 15.
- Drain q2: 16 deqs -> upd_count 15..0, final upd_last = 0, rd_empty = 1. An extra deq -> err_udf pulse, no count change.
- Simultaneous enq && deq on q1 at count 5 -> upd_count = 5, upd_last = 4, no error. The same on an empty queue -> count 0, no error.
- Clear: load q0..q3 = 3,7,1,16, assert clr with op_valid high -> op not accepted, busy high exactly 4 cycles, then all counts 0 and op_ready = 1.
- Async reset mid-sweep and mid-op (rst_n dropped between clock edges) -> outputs zero immediately, no upd_valid after release.
